// File: rtl/button_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing constants for a 12 MHz board clock.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 10 ms debounce, 0.5 s first long press, 100 ms auto-repeat at 12 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 120000;
  localparam int unsigned DEF_LONG_CYCLES     = 6000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 1200000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs; RESET_VAL
// selects the level presented while in reset (e.g. 1 for active-low pins).
module sync_2ff #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces an active-low push button into a clean level plus one-cycle
// press/release strobes. Long-press/auto-repeat is built with BUTTON_LONG_PRESS_EN.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,  // must be >= 2
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES     // must be <= LONG_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output btn_state_e dbg_state
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic btn_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_n),
    .q   (btn_s)
  );

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             hold_adv;
  logic             hold_clr;

  // cnt counts consecutive samples opposite to the accepted level
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    hold_adv        = 1'b0;
    hold_clr        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = HELD;
          cnt_d         = '0;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
          hold_clr      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          hold_adv = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // a bounce back low resumes the hold without restarting hold time
        if (!btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = IDLE;
          cnt_d           = '0;
          pressed_d       = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned        HOLD_W      = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE    = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_FIRE   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(LONG_CYCLES - REPEAT_CYCLES);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_pulse_q, long_pulse_d;

  // fire as the count would reach LONG_CYCLES, then rewind by one repeat period
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    long_pulse_d = 1'b0;
    if (hold_clr) begin
      hold_cnt_d = '0;
    end else if (hold_adv) begin
      if (hold_cnt_q == HOLD_FIRE) begin
        long_pulse_d = 1'b1;
        hold_cnt_d   = HOLD_RELOAD;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q   <= '0;
      long_pulse_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  assign long_pulse = long_pulse_q;
`else
  logic unused_hold;
  assign unused_hold = hold_adv | hold_clr;
  assign long_pulse  = 1'b0;
`endif

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: vector table, hand-written corner sequences and
// random button traffic checked cycle by cycle against a run-length model.
module tb_button_debouncer;
  import button_pkg::*;

  localparam int D    = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic btn_n;
  logic pressed, press_pulse, release_pulse, long_pulse;
  btn_state_e dbg_state;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (LONG),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (btn_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .dbg_state     (dbg_state)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: accepted level flips after D consecutive opposite
  // synchronized samples; hold time counts low samples seen while settled
  typedef struct {
    logic s1, s2, level;
    int   run, held;
    logic pp, rp, lp;
  } mstate_t;

  mstate_t m;
  logic [3:0] exp_q[$];

  function automatic mstate_t model_reset();
    mstate_t r;
    r.s1 = 1'b1; r.s2 = 1'b1; r.level = 1'b0;
    r.run = 0; r.held = 0;
    r.pp = 1'b0; r.rp = 1'b0; r.lp = 1'b0;
    return r;
  endfunction

  function automatic mstate_t model_next(mstate_t cur, logic b);
    mstate_t nx = cur;
    logic s   = cur.s2;
    logic opp = cur.level ? s : !s;
    nx.s1 = b;
    nx.s2 = cur.s1;
    nx.pp = 1'b0; nx.rp = 1'b0; nx.lp = 1'b0;
    if (opp) begin
      nx.run = cur.run + 1;
      if (nx.run == D) begin
        nx.run   = 0;
        nx.level = !cur.level;
        if (nx.level) begin
          nx.pp   = 1'b1;
          nx.held = 0;
        end else begin
          nx.rp = 1'b1;
        end
      end
    end else begin
      if (cur.level && cur.run == 0) begin
        nx.held = cur.held + 1;
        if (LONG_EN && nx.held >= LONG && ((nx.held - LONG) % REP) == 0) nx.lp = 1'b1;
      end
      nx.run = 0;
    end
    return nx;
  endfunction

  function automatic logic [3:0] model_out(mstate_t x);
    return {x.level, x.pp, x.rp, x.lp};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= model_reset();
      exp_q.delete();
    end else begin
      m <= model_next(m, btn_n);
      exp_q.push_back(model_out(model_next(m, btn_n)));
    end
  end

  // driver: one clock, then compare the DUT against the scoreboard
  task automatic tick(input logic v);
    logic [3:0] e;
    btn_n = v;
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      check("reset_outputs", {pressed, press_pulse, release_pulse, long_pulse}, 0);
    end else if (exp_q.size() == 0) begin
      check("model_queue_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("cycle_outputs", {pressed, press_pulse, release_pulse, long_pulse}, e);
    end
  endtask

  // table-driven vectors: low lo1, high hi1, low lo2, then released
  typedef struct {
    int lo1, hi1, lo2;
    int exp_first;  // edge of first press_pulse from start of lo1, -1 = none
    int exp_np, exp_nr;
  } vec_t;

  vec_t rows[8];
  int r_k, r_first, r_np, r_nr, r_nl;

  task automatic row_tick(input logic v);
    tick(v);
    if (press_pulse) begin
      r_np++;
      if (r_first < 0) r_first = r_k;
    end
    if (release_pulse) r_nr++;
    if (long_pulse) r_nl++;
    r_k++;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    r_k = 0; r_first = -1; r_np = 0; r_nr = 0; r_nl = 0;
    repeat (v.lo1) row_tick(1'b0);
    repeat (v.hi1) row_tick(1'b1);
    repeat (v.lo2) row_tick(1'b0);
    repeat (12) row_tick(1'b1);
    check($sformatf("row%0d_first_press_edge", idx), r_first, v.exp_first);
    check($sformatf("row%0d_press_count", idx), r_np, v.exp_np);
    check($sformatf("row%0d_release_count", idx), r_nr, v.exp_nr);
    check($sformatf("row%0d_long_count", idx), r_nl, 0);
  endtask

  // drive low until press_pulse, bounded; returns edge index or -1
  task automatic press_until(output int at);
    at = -1;
    for (int k = 0; k < 12; k++) begin
      tick(1'b0);
      if (press_pulse) begin
        at = k;
        break;
      end
    end
  endtask

  int at, rel_at, p4, p5, nrel, nextra;
  int long_got[$];
  int long_exp[$];

  initial begin
    rst   = 1'b1;
    btn_n = 1'b1;
    repeat (3) tick(1'b1);
    check("reset_state_idle", int'(dbg_state), int'(IDLE));
    rst = 1'b0;
    repeat (5) tick(1'b1);

    rows[0] = '{15, 0, 0,  5, 1, 1};  // clean press
    rows[1] = '{ 3, 0, 0, -1, 0, 0};  // one sample short
    rows[2] = '{ 4, 0, 0,  5, 1, 1};  // exactly enough samples
    rows[3] = '{ 2, 1, 15, 8, 1, 1};  // bounce before settling
    rows[4] = '{15, 2, 6,  5, 1, 1};  // 2-cycle glitch while held
    rows[5] = '{15, 3, 6,  5, 1, 1};  // longest rejected glitch
    rows[6] = '{15, 4, 6,  5, 2, 2};  // glitch long enough to release
    rows[7] = '{ 3, 1, 3, -1, 0, 0};  // two sub-threshold bursts
    for (int i = 0; i < 8; i++) run_row(rows[i], i);

    // release latency after a hold
    press_until(at);
    check("rel_setup_press_edge", at, 5);
    repeat (3) tick(1'b0);
    rel_at = -1; p4 = -1; p5 = -1; nrel = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1);
      if (k == 4) p4 = pressed;
      if (k == 5) p5 = pressed;
      if (release_pulse) begin
        nrel++;
        if (rel_at < 0) rel_at = k;
      end
    end
    check("release_edge", rel_at, 5);
    check("release_pressed_before", p4, 1);
    check("release_pressed_after", p5, 0);
    check("release_count", nrel, 1);
    repeat (4) tick(1'b1);

    // long press and auto-repeat over a 50-cycle hold
    press_until(at);
    check("long_setup_press_edge", at, 5);
    long_got.delete();
    nextra = 0;
    for (int i = 1; i <= 50; i++) begin
      tick(1'b0);
      if (long_pulse) long_got.push_back(i);
      if (press_pulse || release_pulse) nextra++;
    end
    long_exp.delete();
    if (LONG_EN) long_exp = '{20, 28, 36, 44};
    check("long_count", long_got.size(), long_exp.size());
    for (int i = 0; i < long_exp.size() && i < long_got.size(); i++)
      check($sformatf("long_edge%0d", i), long_got[i], long_exp[i]);
    check("long_no_other_pulses", nextra, 0);
    check("long_still_pressed", pressed, 1);
    repeat (12) tick(1'b1);

    // asynchronous reset while held, released with the button still down
    press_until(at);
    check("rst_setup_press_edge", at, 5);
    repeat (2) tick(1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_pressed", pressed, 0);
    check("rst_async_state", int'(dbg_state), int'(IDLE));
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    press_until(at);
    check("rst_repress_edge", at, 5);
    repeat (12) tick(1'b1);

    // random bouncing traffic with occasional long holds
    begin
      logic lvl = 1'b1;
      int   len;
      for (int r = 0; r < 120; r++) begin
        lvl = ~lvl;
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(25, 60) : $urandom_range(1, 7);
        repeat (len) tick(lvl);
      end
    end
    repeat (12) tick(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, compared=%0d mismatched=%0d", n_cmp, n_mis);
    $fatal(1, "watchdog expired");
  end

endmodule
